// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter: FSM states, request payload,
// default widths and the modulo increment used by the round-robin pointer.
package ram_arb_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Field widths track DEF_AW/DEF_DW; the top casts to its own AW/DW.
  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } req_t;

  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set bit of valid at or after ptr, wrapping
// modulo N; returns a one-hot grant, the winner index and a found flag.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          found,
  output logic [PW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && valid[PW'(wrap_add(32'(ptr), k, N))]) begin
        found = 1'b1;
        idx   = PW'(wrap_add(32'(ptr), k, N));
      end
    end
    grant = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer sharing one synchronous single-port RAM between N_REQ
// requesters. Define RAM_INIT_EN to zero-fill the RAM after every reset.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               ram_en,
  output logic               ram_we,
  output logic [AW-1:0]      ram_address,
  output logic [DW-1:0]      ram_data_in,
  input  logic [DW-1:0]      ram_data_out,
  output logic               busy
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef RAM_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t           state, state_next;
  logic [PW-1:0]    rr_ptr, rr_ptr_next;
  logic             ram_en_next, ram_we_next;
  logic [AW-1:0]    ram_address_next;
  logic [DW-1:0]    ram_data_in_next;
  logic             rd_pend, rd_pend_next;
  logic [PW-1:0]    rd_tag, rd_tag_next;
  logic [N_REQ-1:0] rsp_valid_next;
  logic [DW-1:0]    rdata_hold, rdata_hold_next;
  logic [N_REQ-1:0] grant;
  logic             found;
  logic [PW-1:0]    win;
  logic             xfer;
  req_t             sel;

`ifdef RAM_INIT_EN
  logic [AW-1:0]    init_cnt, init_cnt_next;
  logic             init_done, init_done_next;
`endif

  rr_pick #(.N(N_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .found (found),
    .idx   (win)
  );

  // Ready is a combinational grant so a request can transfer in the cycle it is seen.
  assign req_ready = (state == RUN && !rst && found) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel.we    = req_we[win];
    sel.addr  = DEF_AW'(req_addr[int'(win)*AW +: AW]);
    sel.wdata = DEF_DW'(req_wdata[int'(win)*DW +: DW]);
  end

  // RAM data arrives the cycle after the strobe, aligned with the registered tag.
  assign rsp_rdata = (|rsp_valid) ? ram_data_out : rdata_hold;

`ifdef RAM_INIT_EN
  assign busy = (state != RUN);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_next       = state;
    rr_ptr_next      = rr_ptr;
    ram_en_next      = 1'b0;
    ram_we_next      = 1'b0;
    ram_address_next = ram_address;
    ram_data_in_next = ram_data_in;
    rd_pend_next     = 1'b0;
    rd_tag_next      = rd_tag;
    rsp_valid_next   = '0;
    rdata_hold_next  = rsp_rdata;
`ifdef RAM_INIT_EN
    init_cnt_next    = init_cnt;
    init_done_next   = init_done;
`endif

    if (rd_pend) begin
      rsp_valid_next[rd_tag] = 1'b1;
    end

    case (state)
      INIT: begin
`ifdef RAM_INIT_EN
        // One zero write per cycle; one drain cycle after the counter wraps.
        if (!init_done) begin
          ram_en_next      = 1'b1;
          ram_we_next      = 1'b1;
          ram_address_next = init_cnt;
          ram_data_in_next = '0;
          init_cnt_next    = init_cnt + AW'(1);
          if (init_cnt == '1) begin
            init_done_next = 1'b1;
          end
        end else begin
          init_done_next = 1'b0;
          state_next     = RUN;
        end
`else
        state_next = RUN;
`endif
      end
      RUN: begin
        if (xfer) begin
          rr_ptr_next      = PW'(wrap_add(32'(win), 1, N_REQ));
          ram_en_next      = 1'b1;
          ram_we_next      = sel.we;
          ram_address_next = AW'(sel.addr);
          ram_data_in_next = DW'(sel.wdata);
          rd_pend_next     = !sel.we;
          rd_tag_next      = win;
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      rd_pend     <= 1'b0;
      rd_tag      <= '0;
      rsp_valid   <= '0;
      rdata_hold  <= '0;
    end else begin
      rr_ptr      <= rr_ptr_next;
      ram_en      <= ram_en_next;
      ram_we      <= ram_we_next;
      ram_address <= ram_address_next;
      ram_data_in <= ram_data_in_next;
      rd_pend     <= rd_pend_next;
      rd_tag      <= rd_tag_next;
      rsp_valid   <= rsp_valid_next;
      rdata_hold  <= rdata_hold_next;
    end
  end

`ifdef RAM_INIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      init_cnt  <= init_cnt_next;
      init_done <= init_done_next;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level reference model with
// per-cycle comparison, directed scenarios with literal checks, then random traffic.
module tb_ram_arbiter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [N*8-1:0] req_addr, req_wdata;
  logic [7:0]     rsp_rdata, ram_address, ram_data_in, ram_data_out;
  logic           ram_en, ram_we, busy;

  ram_arbiter #(.N_REQ(N), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous, write-then-read ordered across cycles.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_address] <= ram_data_in;
      else        ram_dout <= ram_mem[ram_address];
    end
  end
  assign ram_data_out = ram_dout;

  // Reference model state.
  typedef struct { int due; int idx; logic [7:0] data; } rsp_t;
  rsp_t       rq[$];
  logic [7:0] gold [256];
  int         cyc, m_ptr, m_init;
  bit         m_run, m_en, m_we;
  logic [7:0] m_addr, m_din, m_hold;

  int         n_chk = 0, n_fail = 0;
  logic [N-1:0] xfer_obs = '0;
  int         grant_log[$], rsp_idx_log[$], rsp_cyc_log[$];
  logic [7:0] rsp_dat_log[$];
  int         last_acc_cyc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic void model_reset();
    rq.delete();
    m_ptr = 0; m_init = 0; m_en = 0; m_we = 0;
    m_addr = 8'h00; m_din = 8'h00; m_hold = 8'h00;
`ifdef RAM_INIT_EN
    m_run = 0;
`else
    m_run = 1;
`endif
  endfunction

  always @(posedge rst) model_reset();

  // Per-cycle comparison against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready, exp_rsp;
    logic [7:0]   exp_rd;
    int           w;
    xfer_obs = req_valid & req_ready;
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_ram_address", ram_address, 0);
      check("rst_ram_data_in", ram_data_in, 0);
`ifdef RAM_INIT_EN
      check("rst_busy", busy, 1);
`else
      check("rst_busy", busy, 0);
`endif
    end else begin
      exp_ready = '0;
      w = -1;
      if (m_run) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      exp_rsp = '0;
      exp_rd  = m_hold;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_rsp[rq[0].idx] = 1'b1;
        exp_rd = rq[0].data;
        m_hold = rq[0].data;
        rq.delete(0);
      end
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, !m_run);
      check("ram_en", ram_en, m_en);
      if (m_en) check("ram_we", ram_we, m_we);
      check("ram_address", ram_address, m_addr);
      check("ram_data_in", ram_data_in, m_din);
      check("rsp_valid", rsp_valid, exp_rsp);
      check("rsp_rdata", rsp_rdata, exp_rd);

      if (rsp_valid != 0) begin
        int ridx;
        ridx = 0;
        for (int k = 0; k < N; k++) if (rsp_valid[k]) ridx = k;
        rsp_idx_log.push_back(ridx);
        rsp_cyc_log.push_back(cyc);
        rsp_dat_log.push_back(rsp_rdata);
      end
      for (int k = 0; k < N; k++) if (xfer_obs[k]) grant_log.push_back(k);

      if (!m_run) begin
        if (m_init < 256) begin
          m_en = 1; m_we = 1; m_addr = 8'(m_init); m_din = 8'h00;
          gold[m_init] = 8'h00;
          m_init++;
        end else begin
          m_run = 1; m_en = 0; m_we = 0;
        end
      end else if (w >= 0) begin
        m_ptr  = (w + 1) % N;
        m_en   = 1;
        m_we   = req_we[w];
        m_addr = req_addr[w*8 +: 8];
        m_din  = req_wdata[w*8 +: 8];
        if (m_we) gold[m_addr] = m_din;
        else      rq.push_back('{cyc + 2, w, gold[m_addr]});
      end else begin
        m_en = 0; m_we = 0;
      end
      cyc++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(int i, bit we, logic [7:0] a, logic [7:0] d);
    bit got;
    got = 0;
    req_we[i] = we;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*8 +: 8] = d;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(posedge clk);
      if (xfer_obs[i]) begin
        got = 1;
        last_acc_cyc = cyc - 1;
        break;
      end
    end
    check("req_accepted", got, 1);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_run();
    for (int t = 0; t < 400; t++) begin
      if (!busy) break;
      tick(1);
    end
    check("busy_released", busy, 0);
  endtask

  task automatic new_req(int i);
    req_we[i] = 1'($urandom);
    req_addr[i*8 +: 8] = 8'($urandom_range(0, 15)) + 8'h60;
    req_wdata[i*8 +: 8] = 8'($urandom);
    req_valid[i] = 1'b1;
  endtask

  initial begin
    int bc, n0;
    logic [N-1:0] got2;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ram_dout = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'($urandom) | 8'h01;
      gold[i] = ram_mem[i];
    end
    cyc = 0;
    model_reset();
    tick(3);
    rst = 1'b0;

    // Power-up sweep length and content.
`ifdef RAM_INIT_EN
    bc = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
    check("init_busy_cycles", bc, 257);
    tick(1);
    do_req(0, 1'b0, 8'h37, 8'h00);
    tick(3);
    check("init_read_data", rsp_dat_log[rsp_dat_log.size()-1], 8'h00);
`else
    check("busy_tied_low", busy, 0);
    tick(1);
`endif

    // Write then read the same address from requester 0.
    do_req(0, 1'b1, 8'h10, 8'hA5);
    do_req(0, 1'b0, 8'h10, 8'h00);
    n0 = last_acc_cyc;
    tick(4);
    check("rd10_idx", rsp_idx_log[rsp_idx_log.size()-1], 0);
    check("rd10_data", rsp_dat_log[rsp_dat_log.size()-1], 8'hA5);
    check("rd10_latency", rsp_cyc_log[rsp_cyc_log.size()-1] - n0, 2);

    // Both requesters hold valid: grants alternate starting with requester 1.
    grant_log.delete();
    req_we = '0;
    req_addr = {8'h02, 8'h01};
    req_valid = 2'b11;
    tick(1);
    for (int t = 0; t < 5; t++) begin
      check("b2b_ram_en", ram_en, 1);
      tick(1);
    end
    req_valid = '0;
    check("b2b_grant_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) check("b2b_grant_seq", grant_log[k], (k + 1) % 2);
    tick(3);

    // Two reads on consecutive cycles return to their own requesters in order.
    do_req(0, 1'b1, 8'h20, 8'h11);
    do_req(0, 1'b1, 8'h21, 8'h22);
    req_we = '0;
    req_addr = {8'h20, 8'h21};
    req_valid = 2'b11;
    got2 = '0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      got2 |= xfer_obs;
      #1;
      req_valid &= ~xfer_obs;
      if (got2 == 2'b11) break;
    end
    req_valid = '0;
    check("pair_accepted", got2, 2'b11);
    tick(4);
    n0 = rsp_idx_log.size();
    check("pair_first_idx", rsp_idx_log[n0-2], 1);
    check("pair_first_data", rsp_dat_log[n0-2], 8'h11);
    check("pair_second_idx", rsp_idx_log[n0-1], 0);
    check("pair_second_data", rsp_dat_log[n0-1], 8'h22);
    check("pair_spacing", rsp_cyc_log[n0-1] - rsp_cyc_log[n0-2], 1);

    // Read immediately after a write to the same address.
    do_req(0, 1'b1, 8'h40, 8'h5C);
    do_req(0, 1'b0, 8'h40, 8'h00);
    tick(4);
    check("raw40_data", rsp_dat_log[rsp_dat_log.size()-1], 8'h5C);

    // Reset the cycle after a read transfer: the read is dropped.
    do_req(1, 1'b0, 8'h10, 8'h00);
    check("pre_rst_ram_en", ram_en, 1);
    n0 = rsp_idx_log.size();
    rst = 1'b1;
    #1;
    check("async_rst_ram_en", ram_en, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check("no_rsp_after_rst", rsp_idx_log.size(), n0);
    wait_run();
    grant_log.delete();
    req_we = '0;
    req_addr = {8'h05, 8'h04};
    req_valid = 2'b11;
    tick(2);
    req_valid = '0;
    check("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : 99, 0);
    tick(3);

    // Random traffic with holds, withdrawals and back-to-back requests.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (xfer_obs[i]) begin
            if ($urandom_range(0, 3) != 0) new_req(i);
            else req_valid[i] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          new_req(i);
        end
      end
    end
    req_valid = '0;
    tick(6);
    check("rsp_drain", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
